// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings, default
// timing parameters and a helper for sizing the shared cycle timer.
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAILED  = 3'd5
    } pll_state_e;

    localparam int DEF_RST_CYC    = 16;
    localparam int DEF_SETTLE_CYC = 256;
    localparam int DEF_WIN_CYC    = 1024;
    localparam int DEF_CW         = 12;
    localparam int DEF_MAX_RETRY  = 3;
    localparam int RETRY_W        = 2;

    // The one timer serves RESET, SETTLE and MEASURE, so it must hold the
    // largest of the three terminal counts.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_fb_edge_sync.sv
// Brings the divided PLL feedback clock into the osc domain and turns each
// rising edge into a single-cycle pulse.
module pll_fb_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fb_clk_i,
    output logic edge_o
);

    // Bits [SYNC_STAGES-1:0] form the synchronizer; the top bit is the
    // edge-detect history flop.
    logic [SYNC_STAGES:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], fb_clk_i};
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the PLL out of reset, qualifies its frequency by counting feedback
// edges over fixed osc windows, and hands the core clock over once it passes.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WIN_CYC    = DEF_WIN_CYC,
    parameter int CW         = DEF_CW,
    parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          start_i,
    input  logic          fb_clk_i,
    input  logic [CW-1:0] expected_count_i,
    input  logic [CW-1:0] tolerance_i,
    output logic          pll_enable_o,
    output logic          pll_resetb_o,
    output logic          clk_sel_o,
    output logic          locked_o,
    output logic          lock_err_o,
    output logic          lock_lost_o,
    output logic [1:0]    retry_cnt_o
);

    localparam int TW = timer_width(RST_CYC, SETTLE_CYC, WIN_CYC);
    localparam logic [TW-1:0]      RST_LAST    = TW'(RST_CYC - 1);
    localparam logic [TW-1:0]      SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]      WIN_LAST    = TW'(WIN_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    pll_state_e         state_q;
    logic [TW-1:0]      timer_q;
    logic [CW-1:0]      count_q;
    logic [RETRY_W-1:0] retry_q;
    logic               pll_enable_q;
    logic               pll_resetb_q;
    logic               clk_sel_q;
    logic               locked_q;
    logic               lock_err_q;
    logic               lock_lost_q;

    logic               fb_edge;
    logic               in_window;
    logic               win_first;
    logic               win_last;
    logic [CW-1:0]      count_d;
    logic [CW:0]        count_ext;
    logic [CW:0]        expected_ext;
    logic [CW:0]        abs_diff;
    logic               win_pass;

    pll_fb_edge_sync #(
        .SYNC_STAGES(2)
    ) u_fb_sync (
        .clk_i   (clock_i),
        .rst_ni  (resetb_i),
        .fb_clk_i(fb_clk_i),
        .edge_o  (fb_edge)
    );

    // count_d already includes a pulse landing on the last window cycle, so
    // the verdict below sees the complete window.
    always_comb begin
        in_window = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
        win_first = (timer_q == '0);
        win_last  = (timer_q == WIN_LAST);
        count_d   = '0;
        if (in_window) begin
            if (win_first) begin
                count_d = CW'(fb_edge);
            end else if (count_q == {CW{1'b1}}) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CW'(fb_edge);
            end
        end
    end

    // One extra bit keeps the subtraction from wrapping.
    always_comb begin
        count_ext    = {1'b0, count_d};
        expected_ext = {1'b0, expected_count_i};
        if (count_ext >= expected_ext) begin
            abs_diff = count_ext - expected_ext;
        end else begin
            abs_diff = expected_ext - count_ext;
        end
        win_pass = (abs_diff <= {1'b0, tolerance_i});
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            retry_q      <= '0;
            pll_enable_q <= 1'b0;
            pll_resetb_q <= 1'b0;
            clk_sel_q    <= 1'b0;
            locked_q     <= 1'b0;
            lock_err_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            lock_lost_q <= 1'b0;
            count_q     <= count_d;
            if (!start_i) begin
                state_q      <= ST_IDLE;
                timer_q      <= '0;
                count_q      <= '0;
                retry_q      <= '0;
                pll_enable_q <= 1'b0;
                pll_resetb_q <= 1'b0;
                clk_sel_q    <= 1'b0;
                locked_q     <= 1'b0;
                lock_err_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_RESET;
                        timer_q      <= '0;
                        retry_q      <= '0;
                        pll_enable_q <= 1'b1;
                        pll_resetb_q <= 1'b0;
                    end
                    ST_RESET: begin
                        if (timer_q == RST_LAST) begin
                            state_q      <= ST_SETTLE;
                            timer_q      <= '0;
                            pll_resetb_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_q == SETTLE_LAST) begin
                            state_q <= ST_MEASURE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (win_last) begin
                            timer_q <= '0;
                            if (win_pass) begin
                                state_q   <= ST_LOCKED;
                                clk_sel_q <= 1'b1;
                                locked_q  <= 1'b1;
                            end else if (retry_q < RETRY_MAX) begin
                                state_q      <= ST_RESET;
                                retry_q      <= retry_q + RETRY_W'(1);
                                pll_resetb_q <= 1'b0;
                            end else begin
                                state_q      <= ST_FAILED;
                                lock_err_q   <= 1'b1;
                                pll_enable_q <= 1'b0;
                                pll_resetb_q <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Windows run back to back; timer wrap starts the next one.
                        if (win_last) begin
                            timer_q <= '0;
                            if (!win_pass) begin
                                state_q      <= ST_RESET;
                                lock_lost_q  <= 1'b1;
                                clk_sel_q    <= 1'b0;
                                locked_q     <= 1'b0;
                                retry_q      <= '0;
                                pll_resetb_q <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    ST_FAILED: begin
                        state_q <= ST_FAILED;
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        timer_q      <= '0;
                        pll_enable_q <= 1'b0;
                        pll_resetb_q <= 1'b0;
                        clk_sel_q    <= 1'b0;
                        locked_q     <= 1'b0;
                        lock_err_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_enable_o = pll_enable_q;
    assign pll_resetb_o = pll_resetb_q;
    assign clk_sel_o    = clk_sel_q;
    assign locked_o     = locked_q;
    assign lock_err_o   = lock_err_q;
    assign lock_lost_o  = lock_lost_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench: a default-sized sequencer walks bring-up, margins, loss,
// retries and aborts; a CW=4 copy with short windows covers saturation.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic        fb_a, fb_b;
    logic        fb_run_a, fb_run_b;
    logic [11:0] exp_a, tol_a;
    logic [3:0]  exp_b, tol_b;

    logic        en_a, rb_a, cs_a, lk_a, err_a, ll_a;
    logic [1:0]  rc_a;
    logic        en_b, rb_b, cs_b, lk_b, err_b, ll_b;
    logic [1:0]  rc_b;

    logic [7:0]  outs_a, outs_b;
    assign outs_a = {en_a, rb_a, cs_a, lk_a, err_a, ll_a, rc_a};
    assign outs_b = {en_b, rb_b, cs_b, lk_b, err_b, ll_b, rc_b};

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = 0;

    pll_lock_sequencer dut_a (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start_a), .fb_clk_i(fb_a),
        .expected_count_i(exp_a), .tolerance_i(tol_a),
        .pll_enable_o(en_a), .pll_resetb_o(rb_a), .clk_sel_o(cs_a),
        .locked_o(lk_a), .lock_err_o(err_a), .lock_lost_o(ll_a),
        .retry_cnt_o(rc_a)
    );

    pll_lock_sequencer #(
        .RST_CYC(4), .SETTLE_CYC(8), .WIN_CYC(40), .CW(4), .MAX_RETRY(3)
    ) dut_b (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start_b), .fb_clk_i(fb_b),
        .expected_count_i(exp_b), .tolerance_i(tol_b),
        .pll_enable_o(en_b), .pll_resetb_o(rb_b), .clk_sel_o(cs_b),
        .locked_o(lk_b), .lock_err_o(err_b), .lock_lost_o(ll_b),
        .retry_cnt_o(rc_b)
    );

    // 10 MHz osc
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Feedback toggles on the falling osc edge: one rising edge per two cycles.
    initial begin
        fb_a = 1'b0;
        fb_b = 1'b0;
        forever begin
            @(negedge clk);
            fb_a = fb_run_a ? ~fb_a : 1'b0;
            fb_b = fb_run_b ? ~fb_b : 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
        end else begin
            $display("ok   %s: %0h (cyc %0d)", tag, got, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // outs = {pll_enable, pll_resetb, clk_sel, locked, lock_err, lock_lost, retry[1:0]}
    initial begin
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        fb_run_a = 1'b1;
        fb_run_b = 1'b1;
        exp_a    = 12'd512;
        tol_a    = 12'd4;
        exp_b    = 4'd15;
        tol_b    = 4'd0;

        repeat (3) tick();
        check_eq("reset_a", 32'(outs_a), 32'h00);
        check_eq("reset_b", 32'(outs_b), 32'h00);
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("idle_a", 32'(outs_a), 32'h00);

        // Nominal bring-up: count 512 against 512+/-4
        cyc = 0;
        start_a = 1'b1;
        run_to(1);    check_eq("t1_enable",        32'(outs_a), 32'h80);
        run_to(16);   check_eq("t1_rst_held",      32'(outs_a), 32'h80);
        run_to(17);   check_eq("t1_rst_release",   32'(outs_a), 32'hC0);
        run_to(1296); check_eq("t1_pre_lock",      32'(outs_a), 32'hC0);
        run_to(1297); check_eq("t1_lock",          32'(outs_a), 32'hF0);

        // Margins while locked: |512-516| = 4 and |512-508| = 4 both pass
        exp_a = 12'd516;
        run_to(2321); check_eq("t2_pass_hi",       32'(outs_a), 32'hF0);
        exp_a = 12'd508;
        run_to(3345); check_eq("t2_pass_lo",       32'(outs_a), 32'hF0);

        // Lock loss: stop feedback mid-window
        run_to(3400); fb_run_a = 1'b0;
        run_to(4368); check_eq("t4_before_end",    32'(outs_a), 32'hF0);
        run_to(4369); check_eq("t4_lock_lost",     32'(outs_a), 32'h84);
        run_to(4370); check_eq("t4_pulse_end",     32'(outs_a), 32'h80);
        run_to(4385); check_eq("t4_rst_release",   32'(outs_a), 32'hC0);
        run_to(4400); fb_run_a = 1'b1; exp_a = 12'd507;

        // Marginal fail from MEASURE: |512-507| = 5 > 4
        run_to(5665); check_eq("t2_fail_retry1",   32'(outs_a), 32'h81);
        run_to(5680); check_eq("t2_rst_held",      32'(outs_a), 32'h81);
        run_to(5681); check_eq("t2_rst_release",   32'(outs_a), 32'hC1);

        // Never locks: feedback dead for the remaining retries
        run_to(5700); fb_run_a = 1'b0;
        run_to(6961); check_eq("t3_retry2",        32'(outs_a), 32'h82);
        run_to(8257); check_eq("t3_retry3",        32'(outs_a), 32'h83);
        run_to(9552); check_eq("t3_last_window",   32'(outs_a), 32'hC3);
        run_to(9553); check_eq("t3_lock_err",      32'(outs_a), 32'h0B);
        run_to(9560); check_eq("t3_err_sticky",    32'(outs_a), 32'h0B);
        start_a = 1'b0;
        run_to(9561); check_eq("t3_err_clear",     32'(outs_a), 32'h00);

        // Abort with start=0 mid-MEASURE
        fb_run_a = 1'b1;
        exp_a    = 12'd512;
        run_to(9570); start_a = 1'b1;
        run_to(10000); check_eq("t5_in_measure",   32'(outs_a), 32'hC0);
        start_a = 1'b0;
        run_to(10001); check_eq("t5_start_abort",  32'(outs_a), 32'h00);

        // Asynchronous reset mid-SETTLE
        run_to(10010); start_a = 1'b1;
        run_to(10100); check_eq("t5_in_settle",    32'(outs_a), 32'hC0);
        #20 rst_n = 1'b0;
        #10 check_eq("t5_async_reset", 32'(outs_a), 32'h00);
        start_a = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t5_idle_after_reset", 32'(outs_a), 32'h00);

        // Saturation: 20 edges per 40-cycle window in a 4-bit counter
        base = cyc;
        start_b = 1'b1;
        run_to(base + 1);  check_eq("t6_enable",      32'(outs_b), 32'h80);
        run_to(base + 5);  check_eq("t6_rst_release", 32'(outs_b), 32'hC0);
        run_to(base + 52); check_eq("t6_pre_lock",    32'(outs_b), 32'hC0);
        run_to(base + 53); check_eq("t6_sat_pass",    32'(outs_b), 32'hF0);
        exp_b = 4'd10;
        tol_b = 4'd2;
        run_to(base + 92); check_eq("t6_still_lock",  32'(outs_b), 32'hF0);
        run_to(base + 93); check_eq("t6_sat_fail",    32'(outs_b), 32'h84);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
